// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: input-side controller for a 3x3 Sobel window built on a
// double line buffer. It accepts one frame of pixels, forwards each pixel to the
// line buffer one cycle later, and reports when the 3x3 window is valid at the
// buffer outputs. At frame end it flushes both line stores to zero.
module sobel_window_ctrl #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          pix_valid_i,
  input  logic [7:0]                    pix_data_i,
  output logic                          pix_ready_o,
  output logic                          lb_we_o,
  output logic [7:0]                    lb_data_o,
  input  logic                          lb_done_i,
  output logic                          win_valid_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row_o,
  output logic                          border_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          err_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int FW = $clog2(2*IMG_WIDTH+1);

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH-1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT-1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2*IMG_WIDTH-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [FW-1:0] flush_cnt;
  logic          xfer;
  logic          last_pix;
  // Marks that the write currently on lb_we_o came from a RUN pixel on row>=1,
  // i.e. one that depends on the line buffer already holding a line.
  logic          wr_needs_line;

  assign xfer     = pix_valid_i & pix_ready_o;
  assign last_pix = (col == COL_LAST) && (row == ROW_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (xfer && last_pix) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt == FLUSH_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    pix_ready_o  = 1'b0;
    busy_o       = 1'b1;
    frame_done_o = 1'b0;
    case (state)
      IDLE:    busy_o       = 1'b0;
      RUN:     pix_ready_o  = 1'b1;
      DONE:    frame_done_o = 1'b1;
      default: ;
    endcase
  end

  // Input position counters: cleared on frame start, advance on transfer only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && start_i) begin
      col <= '0;
      row <= '0;
    end else if (xfer) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Flush write counter, runs only while in FLUSH; tops out at 2*IMG_WIDTH-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  flush_cnt <= '0;
    else if (state == FLUSH)  flush_cnt <= (flush_cnt == FLUSH_LAST) ? '0 : flush_cnt + FW'(1);
    else                      flush_cnt <= '0;
  end

  // Line-buffer write port and window tag, one cycle behind the transfer.
  // Window position registers only move when a valid window is reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb_we_o       <= 1'b0;
      lb_data_o     <= '0;
      win_valid_o   <= 1'b0;
      win_col_o     <= '0;
      win_row_o     <= '0;
      border_o      <= 1'b0;
      wr_needs_line <= 1'b0;
    end else if (xfer) begin
      lb_we_o       <= 1'b1;
      lb_data_o     <= pix_data_i;
      wr_needs_line <= (row != '0);
      win_valid_o   <= (row >= RW'(2));
      if (row >= RW'(2)) begin
        win_col_o <= col;
        win_row_o <= row - RW'(1);
        border_o  <= (col == '0) || (col == COL_LAST);
      end
    end else if (state == FLUSH) begin
      lb_we_o       <= 1'b1;
      lb_data_o     <= '0;
      win_valid_o   <= 1'b0;
      wr_needs_line <= 1'b0;
    end else begin
      lb_we_o       <= 1'b0;
      win_valid_o   <= 1'b0;
      wr_needs_line <= 1'b0;
    end
  end

  // Sticky error: a write that needs a stored line issued before the buffer has one
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      err_o <= 1'b0;
    else if (lb_we_o && wr_needs_line && !lb_done_i) err_o <= 1'b1;
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Bench for sobel_window_ctrl at 4x4. The driver pushes the expected line-buffer
// write for every accepted pixel (and the flush zeros after the last pixel); a
// negedge monitor pops and compares each write the DUT produces.
module tb_sobel_window_ctrl;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       pix_valid_i;
  logic [7:0] pix_data_i;
  logic       pix_ready_o;
  logic       lb_we_o;
  logic [7:0] lb_data_o;
  logic       lb_done_i;
  logic       win_valid_o;
  logic [1:0] win_col_o;
  logic [1:0] win_row_o;
  logic       border_o;
  logic       busy_o;
  logic       frame_done_o;
  logic       err_o;

  sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pix_valid_i(pix_valid_i),
    .pix_data_i(pix_data_i), .pix_ready_o(pix_ready_o), .lb_we_o(lb_we_o),
    .lb_data_o(lb_data_o), .lb_done_i(lb_done_i), .win_valid_o(win_valid_o),
    .win_col_o(win_col_o), .win_row_o(win_row_o), .border_o(border_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       wv;
    int         col;
    int         row;
    logic       border;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int win_cnt = 0;
  int fd_cnt = 0;

  // Scoreboard monitor: every DUT write is popped against the expected queue
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (frame_done_o) fd_cnt++;
      if (win_valid_o) win_cnt++;
      if (win_valid_o && !lb_we_o) begin
        n_cmp++; n_bad++;
        $display("FAIL win_without_write: win_valid_o=1 while lb_we_o=0 at %0t", $time);
      end
      if (lb_we_o) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL extra_write: got data=%0d, expected no write", lb_data_o);
        end else begin
          e = q.pop_front();
          if (lb_data_o !== e.data || win_valid_o !== e.wv) begin
            n_bad++;
            $display("FAIL write: got data=%0d wv=%b, expected data=%0d wv=%b",
                     lb_data_o, win_valid_o, e.data, e.wv);
          end else if (e.wv && (win_col_o !== e.col[1:0] || win_row_o !== e.row[1:0] ||
                                border_o !== e.border)) begin
            n_bad++;
            $display("FAIL window: got col=%0d row=%0d border=%b, expected col=%0d row=%0d border=%b",
                     win_col_o, win_row_o, border_o, e.col, e.row, e.border);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one whole frame; pixels 1..16. Optional stalls, mid-frame start, error probe
  task automatic run_frame(input bit toggle, input bit start_mid, input bit err_probe);
    int c = 0, r = 0, p = 1, guard = 0;
    exp_t e;
    win_cnt = 0; fd_cnt = 0;
    start_i = 1'b1; tick(); start_i = 1'b0;
    while (p <= W*H && guard < 200) begin
      guard++;
      if (err_probe && p == 5) begin
        n_cmp++;
        if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_early: got %b, expected 0", err_o); end
      end
      if (err_probe && p == 7) begin
        n_cmp++;
        if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b, expected 1", err_o); end
      end
      if (toggle && (guard % 2 == 0)) begin
        pix_valid_i = 1'b0; pix_data_i = 8'hEE; tick();
        continue;
      end
      pix_valid_i = 1'b1; pix_data_i = 8'(p);
      if (start_mid && p == 8) start_i = 1'b1;
      #1;
      n_cmp++;
      if (pix_ready_o !== 1'b1) begin
        n_bad++; $display("FAIL ready_run: got %b, expected 1 (pixel %0d)", pix_ready_o, p);
      end
      e.data = 8'(p); e.wv = (r >= 2); e.col = c; e.row = r - 1; e.border = (c == 0 || c == W-1);
      q.push_back(e);
      if (p == W*H) begin
        for (int k = 0; k < 2*W; k++) begin
          e.data = 8'd0; e.wv = 1'b0; e.col = 0; e.row = 0; e.border = 1'b0;
          q.push_back(e);
        end
      end
      c++; if (c == W) begin c = 0; r++; end
      p++;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    pix_valid_i = 1'b0;
    guard = 0;
    while (busy_o && guard < 50) begin tick(); guard++; end
    tick(); tick();
    n_cmp++;
    if (busy_o !== 1'b0) begin n_bad++; $display("FAIL busy_end: got %b, expected 0", busy_o); end
    n_cmp++;
    if (win_cnt !== (H-2)*W) begin n_bad++; $display("FAIL win_count: got %0d, expected %0d", win_cnt, (H-2)*W); end
    n_cmp++;
    if (fd_cnt !== 1) begin n_bad++; $display("FAIL frame_done_count: got %0d, expected 1", fd_cnt); end
    n_cmp++;
    if (q.size() !== 0) begin n_bad++; $display("FAIL missing_writes: %0d left, expected 0", q.size()); end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if ({pix_ready_o, lb_we_o, lb_data_o, win_valid_o, win_col_o, win_row_o,
         border_o, busy_o, frame_done_o, err_o} !== 17'd0) begin
      n_bad++;
      $display("FAIL %s: outputs rdy=%b we=%b d=%0d wv=%b c=%0d r=%0d b=%b busy=%b fd=%b err=%b, expected all 0",
               tag, pix_ready_o, lb_we_o, lb_data_o, win_valid_o, win_col_o, win_row_o,
               border_o, busy_o, frame_done_o, err_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; pix_valid_i = 1'b0; pix_data_i = 8'd0; lb_done_i = 1'b1;
    tick(); tick();
    check_reset_outputs("reset_state");
    rst = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    run_frame(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_clean: got %b, expected 0", err_o); end
  endtask

  task automatic test_stalls();
    run_frame(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_idle_ignore();
    pix_valid_i = 1'b1; pix_data_i = 8'h55;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (pix_ready_o !== 1'b0 || lb_we_o !== 1'b0) begin
        n_bad++; $display("FAIL idle_ignore: got ready=%b we=%b, expected 0 0", pix_ready_o, lb_we_o);
      end
    end
    pix_valid_i = 1'b0;
  endtask

  task automatic test_start_in_run();
    run_frame(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_err();
    lb_done_i = 1'b0;
    run_frame(1'b0, 1'b0, 1'b1);
    tick(); tick();
    n_cmp++;
    if (err_o !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b, expected 1", err_o); end
    lb_done_i = 1'b1;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    start_i = 1'b1; tick(); start_i = 1'b0;
    for (int p = 1; p <= 6; p++) begin
      pix_valid_i = 1'b1; pix_data_i = 8'(p);
      e.data = 8'(p); e.wv = 1'b0; e.col = 0; e.row = 0; e.border = 1'b0;
      q.push_back(e);
      tick();
    end
    pix_valid_i = 1'b0;
    rst = 1'b1; q.delete(); #1;
    check_reset_outputs("mid_reset_immediate");
    tick();
    check_reset_outputs("mid_reset_held");
    rst = 1'b0; tick();
    run_frame(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stalls();
    test_idle_ignore();
    test_start_in_run();
    test_err();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
